key_pulse_gen: RTL and testbench

Front-end conditioner for the up/down pushbuttons. It synchronizes and debounces two raw key levels and turns them into single-cycle count / deCount pulses, with optional hold-to-repeat. It sits directly upstream of the 4-bit up/down counter and drives that counter's count and deCount inputs.

---
 rtl/key_pulse_gen_pkg.sv | 16 +
 rtl/key_pulse_gen_if.sv | 10 +
 rtl/key_pulse_gen_debounce.sv | 46 ++++
 rtl/key_pulse_gen.sv | 152 +++++++++++++++
 tb/tb_key_pulse_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/key_pulse_gen_pkg.sv
// Shared types and helpers for the up/down key pulse generator.
package key_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UP_HELD   = 2'd1,
    DOWN_HELD = 2'd2,
    LOCK      = 2'd3
  } key_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// Key inputs and pulse outputs between the board buttons and the up/down counter.
interface key_pulse_gen_if;
  logic key_up;
  logic key_down;
  logic count;
  logic deCount;

  modport master (output key_up, output key_down, input count, input deCount);
  modport slave  (input key_up, input key_down, output count, output deCount);
endinterface

// File: rtl/key_pulse_gen_debounce.sv
// Two-flop synchronizer followed by a stability filter for one raw key level.
module key_debounce
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] stable_reg;

  // stable_reg counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      level_reg  <= 1'b0;
      stable_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        if (stable_reg == LAST) begin
          level_reg  <= sync2_reg;
          stable_reg <= '0;
        end else begin
          stable_reg <= stable_reg + CW'(1);
        end
      end else begin
        stable_reg <= '0;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced up/down keys -> single-cycle count/deCount pulses.
// Define AUTO_REPEAT_EN to compile hold-to-repeat; otherwise one pulse per press.
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  key_pulse_gen_if.slave   bus
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_pulse_gen: cycle parameters must be at least 1");
  end

  logic [1:0] raw_keys;
  logic [1:0] filt_lvl;
  logic       fu;
  logic       fd;

  assign raw_keys = {bus.key_down, bus.key_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_keys[gi]),
      .level (filt_lvl[gi])
    );
  end

  assign fu = filt_lvl[0];
  assign fd = filt_lvl[1];

  key_state_t state_reg, state_next;
  logic       count_reg, count_next;
  logic       decount_reg, decount_next;
  logic       rpt_fire;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RPT_MAX);

  logic          holding;
  logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [RW-1:0] rpt_thr;
  logic          rpt_periodic_reg, rpt_periodic_next;

  // Anything other than a single key steadily held (re)arms the initial delay.
  always_comb begin
    holding = (state_reg == UP_HELD && fu && !fd) ||
              (state_reg == DOWN_HELD && fd && !fu);
    rpt_thr = rpt_periodic_reg ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    rpt_fire          = 1'b0;
    rpt_cnt_next      = '0;
    rpt_periodic_next = 1'b0;
    if (holding) begin
      if (rpt_cnt_reg == rpt_thr) begin
        rpt_fire          = 1'b1;
        rpt_periodic_next = 1'b1;
      end else begin
        rpt_cnt_next      = rpt_cnt_reg + RW'(1);
        rpt_periodic_next = rpt_periodic_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_reg      <= '0;
      rpt_periodic_reg <= 1'b0;
    end else begin
      rpt_cnt_reg      <= rpt_cnt_next;
      rpt_periodic_reg <= rpt_periodic_next;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    count_next   = 1'b0;
    decount_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fu && fd) begin
          state_next = LOCK;
        end else if (fu) begin
          state_next = UP_HELD;
          count_next = 1'b1;
        end else if (fd) begin
          state_next   = DOWN_HELD;
          decount_next = 1'b1;
        end
      end
      UP_HELD: begin
        if (!fu && !fd) begin
          state_next = IDLE;
        end else if (fd) begin
          if (fu) begin
            state_next = LOCK;
          end else begin
            state_next   = DOWN_HELD;
            decount_next = 1'b1;
          end
        end else begin
          count_next = rpt_fire;
        end
      end
      DOWN_HELD: begin
        if (!fu && !fd) begin
          state_next = IDLE;
        end else if (fu) begin
          if (fd) begin
            state_next = LOCK;
          end else begin
            state_next = UP_HELD;
            count_next = 1'b1;
          end
        end else begin
          decount_next = rpt_fire;
        end
      end
      LOCK: begin
        if (!fu && !fd) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= 1'b0;
      decount_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      decount_reg <= decount_next;
    end
  end

  assign bus.count   = count_reg;
  assign bus.deCount = decount_reg;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen; repeat expectations follow AUTO_REPEAT_EN.
module tb_key_pulse_gen;
  import key_pulse_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  key_pulse_gen_if bus ();

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] st;
    reset = 1'b1;
    bus.key_up = 1'b1;
    bus.key_down = 1'b1;
    repeat (6) step();
    st = dut.state_reg;
    total++; if (bus.count !== 1'b0) begin bad++; $display("FAIL reset_count got=%b want=0", bus.count); end
    total++; if (bus.deCount !== 1'b0) begin bad++; $display("FAIL reset_decount got=%b want=0", bus.deCount); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
    total++; if (dut.filt_lvl !== 2'b00) begin bad++; $display("FAIL reset_level got=%b want=00", dut.filt_lvl); end
    $display("reset: count=%b deCount=%b state=%0d", bus.count, bus.deCount, st);
    apply_reset();
  endtask

  // Up held edges 0..9: one count after edge 6, nothing on release.
  task automatic test_single_press();
    logic exp_c;
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      bus.key_up = (k < 10);
      step();
      exp_c = (k == 6);
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL single_count k=%0d got=%b want=%b", k, bus.count, exp_c); end
      total++; if (bus.deCount !== 1'b0) begin bad++; $display("FAIL single_decount k=%0d got=%b want=0", k, bus.deCount); end
    end
    $display("single_press: done");
  endtask

  // 3-high / 2-low glitches never reach the filter threshold.
  task automatic test_glitch();
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      bus.key_up = ((k % 5) < 3);
      step();
      total++; if (bus.count !== 1'b0) begin bad++; $display("FAIL glitch_count k=%0d got=%b want=0", k, bus.count); end
      total++; if (dut.filt_lvl[0] !== 1'b0) begin bad++; $display("FAIL glitch_level k=%0d got=%b want=0", k, dut.filt_lvl[0]); end
    end
    bus.key_up = 1'b0;
    $display("glitch: done");
  endtask

  // Down held edges 0..59; the would-be pulse at edge 66 is cancelled by release.
  task automatic test_repeat();
    logic exp_d;
    apply_reset();
    for (int k = 0; k < 90; k++) begin
      bus.key_down = (k < 60);
      step();
`ifdef AUTO_REPEAT_EN
      exp_d = (k == 6) || (k == 26) || (k == 34) || (k == 42) || (k == 50) || (k == 58);
`else
      exp_d = (k == 6);
`endif
      total++; if (bus.deCount !== exp_d) begin bad++; $display("FAIL repeat_decount k=%0d got=%b want=%b", k, bus.deCount, exp_d); end
      total++; if (bus.count !== 1'b0) begin bad++; $display("FAIL repeat_count k=%0d got=%b want=0", k, bus.count); end
    end
    $display("repeat: done");
  endtask

  // Up held, down joins -> LOCK; release down, then up; fresh down press pulses once.
  task automatic test_lock();
    logic       exp_c;
    logic       exp_d;
    logic [1:0] st;
    apply_reset();
    for (int k = 0; k < 62; k++) begin
      bus.key_up   = (k < 30);
      bus.key_down = (k >= 10 && k < 20) || (k >= 40 && k < 50);
      step();
      exp_c = (k == 6);
      exp_d = (k == 46);
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL lock_count k=%0d got=%b want=%b", k, bus.count, exp_c); end
      total++; if (bus.deCount !== exp_d) begin bad++; $display("FAIL lock_decount k=%0d got=%b want=%b", k, bus.deCount, exp_d); end
      total++; if (bus.count && bus.deCount) begin bad++; $display("FAIL lock_overlap k=%0d got=11 want=not both", k); end
      if (k == 20 || k == 30) begin
        st = dut.state_reg;
        total++; if (st !== 2'd3) begin bad++; $display("FAIL lock_state k=%0d got=%0d want=3", k, st); end
      end
    end
    $display("lock: done");
  endtask

  // Reset sampled at edge 6 kills the pulse; held key re-pulses at edge 13.
  task automatic test_reset_mid_press();
    logic exp_c;
    apply_reset();
    for (int k = 0; k < 26; k++) begin
      bus.key_up = 1'b1;
      reset = (k == 6);
      step();
      exp_c = (k == 13);
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL midrst_count k=%0d got=%b want=%b", k, bus.count, exp_c); end
      total++; if (bus.deCount !== 1'b0) begin bad++; $display("FAIL midrst_decount k=%0d got=%b want=0", k, bus.deCount); end
    end
    reset = 1'b0;
    $display("reset_mid_press: done");
  endtask

  // Press, release, press again: two counts, none on either release.
  task automatic test_back_to_back();
    logic exp_c;
    apply_reset();
    for (int k = 0; k < 44; k++) begin
      bus.key_up = (k < 10) || (k >= 20 && k < 30);
      step();
      exp_c = (k == 6) || (k == 26);
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL b2b_count k=%0d got=%b want=%b", k, bus.count, exp_c); end
      total++; if (bus.count && bus.deCount) begin bad++; $display("FAIL b2b_overlap k=%0d got=11 want=not both", k); end
    end
    $display("back_to_back: done");
  endtask

  initial begin
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_lock();
    test_reset_mid_press();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
